seq_alu_exec: RTL and testbench
===============================

Name: seq_alu_exec

Overview:
- Execute-side consumer of the 4-bit aluControl code produced by the ALU decoder.
- Performs the selected RV32I integer operation on two operands and returns the result over a valid/ready handshake.
- Logic/arithmetic/compare ops complete in one cycle; shifts run iteratively, one bit per cycle, to save area.
- Sits between operand fetch and writeback in a multi-cycle datapath variant.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- aluControl  input  4  operation code; encoding below.
- srcA  input  XLEN  operand A.
- srcB  input  XLEN  operand B; shifts use srcB[SHW-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0.
- illegal  output  1  aluControl was an unused code.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRA, 7 SRL, 8 OR, 9 AND.
  - 0xA–0xF are illegal.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready. Operands and code are latched on accept; later input changes are ignored.
- IDLE, accept of a non-shift op (incl. illegal) → DONE next cycle:
  - result registered; latency 1 cycle.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU return 0 or 1, zero-extended.
  - Illegal code: result=0, illegal=1, zero=1.
- IDLE, accept of a shift (2/6/7):
  - Load acc=srcA, cnt=srcB[SHW-1:0]; upper srcB bits are ignored.
  - cnt==0 → DONE next cycle with result=srcA.
  - Otherwise → SHIFT.
- SHIFT: each cycle shift acc by 1 (SLL fills 0; SRL fills 0; SRA replicates the MSB) and decrement cnt. When cnt reaches 0 that cycle, → DONE with result=acc. Total latency from accept to out_valid = max(cnt,1) cycles.
- DONE:
  - out_valid=1; result/zero/illegal held stable until out_ready.
  - out_valid & out_ready → IDLE next cycle, out_valid=0.
  - result retains its last value; illegal clears on the next accept.
- No back-to-back acceptance: minimum 2 cycles per op (accept, DONE).
- zero is always registered together with result.
- Reset asserted mid-SHIFT or in DONE: immediate return to reset values; the pending result is discarded and no out_valid is issued for it.
- in_valid while busy: ignored (in_ready=0); the producer must hold its request.

Test Plan:
- Reset then ADD: srcA=0x7FFFFFFF, srcB=1, code 0 → out_valid one cycle after accept, result=0x80000000, zero=0; SUB 5−5 → result=0, zero=1.
- Compares: srcA=0xFFFFFFFF, srcB=1 → SLT result=1, SLTU result=0; XOR/OR/AND of 0xF0F0F0F0 with 0x0FF00FF0 → 0xFF00FF00, 0xFFF0FFF0, 0x00F000F0.
- Shifts:
  - SRA srcA=0x80000000, srcB=31 → 0xFFFFFFFF with out_valid exactly 31 cycles after accept.
  - SRL same operands → 0x00000001.
  - SLL srcA=1, srcB=0x25 (shamt 5) → 0x20 after 5 cycles.
  - Shamt 0 → srcA after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, a new in_valid is ignored; raise out_ready → IDLE, the next request is accepted.
- Illegal code 0xC with srcA=srcB=0x12345678 → result=0, illegal=1, zero=1; the next legal op clears illegal.
- Assert reset 3 cycles into SRL shamt=20 → out_valid=0, in_ready=1 immediately; no stale result is delivered after reset release, and a fresh ADD completes correctly.

Source files
------------

// File: rtl/seq_alu_exec.sv
// seq_alu_exec: RV32I integer execute unit behind a valid/ready handshake.
// Logic, arithmetic and compare ops finish in one cycle. Shifts iterate one
// bit position per cycle.
module seq_alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      aluControl,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRA  = 4'd6,
        OP_SRL  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } op_e;

    state_e          state;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  cnt;
    logic [3:0]      op_q;

    logic            accept;
    logic            is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [XLEN-1:0] first_step;
    logic [XLEN-1:0] next_step;

    // Single-position shift for one of the three shift codes.
    function automatic logic [XLEN-1:0] shift1(input logic [3:0] op,
                                               input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (op)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = {1'b0, v[XLEN-1:1]};
        endcase
        return r;
    endfunction

    assign accept     = in_valid & in_ready;
    assign shamt      = srcB[SHW-1:0];
    assign is_shift   = (aluControl == OP_SLL) || (aluControl == OP_SRA) ||
                        (aluControl == OP_SRL);
    assign first_step = shift1(aluControl, srcA);
    assign next_step  = shift1(op_q, acc);

    // Single-cycle result for non-shift codes; unused codes flag illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (aluControl)
            OP_ADD:  alu_res = srcA + srcB;
            OP_SUB:  alu_res = srcA - srcB;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (srcA < srcB)};
            OP_XOR:  alu_res = srcA ^ srcB;
            OP_OR:   alu_res = srcA | srcB;
            OP_AND:  alu_res = srcA & srcB;
            OP_SLL, OP_SRA, OP_SRL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    // The first shift step is taken in the accept cycle so that a shift by
    // n raises out_valid n cycles after accept; cnt then holds the steps left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        op_q     <= aluControl;
                        if (is_shift) begin
                            illegal <= 1'b0;
                            if (shamt == '0) begin
                                result    <= srcA;
                                zero      <= (srcA == '0);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end else if (shamt == SHW'(1)) begin
                                result    <= first_step;
                                zero      <= (first_step == '0);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                acc   <= first_step;
                                cnt   <= shamt - SHW'(1);
                                state <= SHIFT;
                            end
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            illegal   <= alu_ill;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc <= next_step;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result    <= next_step;
                        zero      <= (next_step == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Self-checking bench for seq_alu_exec: directed vector table, hand-written
// handshake/reset sequences, and random ops against an arithmetic model.
module tb_seq_alu_exec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  aluControl = '0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail = 0;

    seq_alu_exec #(.XLEN(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .aluControl(aluControl),
        .srcA(srcA),
        .srcB(srcB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32I semantics written directly with SV operators.
    function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh = b % 32;
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return $unsigned($signed(a) >>> sh);
            4'd7: return a >> sh;
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        int sh = int'(b % 32);
        if (c == 4'd2 || c == 4'd6 || c == 4'd7) return (sh == 0) ? 1 : sh;
        return 1;
    endfunction

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Issue one op, scramble inputs after accept, return captured outputs.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] r, output logic z,
                          output logic ill, output int lat, output logic stable);
        int k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b1;
        aluControl = code;
        srcA = a;
        srcB = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        aluControl = 4'($urandom);
        srcA = $urandom;
        srcB = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        z = zero;
        ill = illegal;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (result !== r || zero !== z || illegal !== ill || out_valid !== 1'b1 ||
                in_ready !== 1'b0)
                stable = 1'b0;
        end
        release_out();
    endtask

    initial begin
        logic [31:0] r;
        logic        z, ill, stable, stale;
        int          lat;

        vecs[0]  = '{"add_ovf",  4'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_zero", 4'd1, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 1};
        vecs[2]  = '{"slt",      4'd3, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0, 1};
        vecs[3]  = '{"sltu",     4'd4, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b0, 1};
        vecs[4]  = '{"xor",      4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1};
        vecs[5]  = '{"or",       4'd8, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1};
        vecs[6]  = '{"and",      4'd9, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1};
        vecs[7]  = '{"sra31",    4'd6, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 31};
        vecs[8]  = '{"srl31",    4'd7, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 31};
        vecs[9]  = '{"sll5",     4'd2, 32'd1,        32'h25,       32'h00000020, 1'b0, 1'b0, 5};
        vecs[10] = '{"shamt0",   4'd2, 32'h0000ABCD, 32'h40,       32'h0000ABCD, 1'b0, 1'b0, 1};
        vecs[11] = '{"illegal",  4'hC, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1};
        vecs[12] = '{"ill_clr",  4'd0, 32'd3,        32'd4,        32'h00000007, 1'b0, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero_ill", {30'd0, zero, illegal}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, 0, r, z, ill, lat, stable);
            check({vecs[i].name, "_res"}, r, vecs[i].res);
            check({vecs[i].name, "_zero"}, 32'(z), 32'(vecs[i].z));
            check({vecs[i].name, "_ill"}, 32'(ill), 32'(vecs[i].ill));
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: hold DONE 10 cycles with a competing request pending
        in_valid = 1'b1; aluControl = 4'd2; srcA = 32'd3; srcB = 32'd4;
        @(posedge clk); #1;
        aluControl = 4'd0; srcA = 32'd100; srcB = 32'd1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd4);
        check("bp_res", result, 32'h30);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (result !== 32'h30 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_res", result, 32'd101);
        release_out();

        // Reset three cycles into a 20-bit SRL
        in_valid = 1'b1; aluControl = 4'd7; srcA = 32'hFFFFFFFF; srcB = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stale = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("no_stale", 32'(stale), 32'd0);
        run_op(4'd0, 32'd40, 32'd2, 0, r, z, ill, lat, stable);
        check("post_rst_add", r, 32'd42);
        check("post_rst_lat", 32'(lat), 32'd1);

        // Random ops against the model, with random consumer stalls
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b, er;
            int          hold;
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            a = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 5) == 0) ? a : $urandom;
            hold = $urandom_range(0, 3);
            er = model_res(c, a, b);
            run_op(c, a, b, hold, r, z, ill, lat, stable);
            check("rnd_res", r, er);
            check("rnd_zero", 32'(z), 32'(er == 32'd0));
            check("rnd_ill", 32'(ill), 32'(c > 4'd9));
            check("rnd_lat", 32'(lat), 32'(model_lat(c, b)));
            check("rnd_stable", 32'(stable), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
